reg_file_wr_arbiter: RTL



---
 rtl/reg_file_wr_arbiter_if.sv | 29 ++
 rtl/reg_file_wr_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/reg_file_wr_arbiter_if.sv
// Request-side bundle for reg_file_wr_arbiter.
// Carries the two requesters' valid/ready write handshakes.
//   master : requester side (drives valid/addr/data, observes ready)
//   slave  : arbiter side   (observes valid/addr/data, drives ready)
interface reg_file_wr_arbiter_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 5
);
  logic                   req0_valid;
  logic [ADDR_WIDTH-1:0]  req0_addr;
  logic [WORD_LENGTH-1:0] req0_data;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [ADDR_WIDTH-1:0]  req1_addr;
  logic [WORD_LENGTH-1:0] req1_data;
  logic                   req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Two-requester round-robin write-port arbiter for the register file.
// Picks at most one request per cycle and drives a registered one-hot
// enable vector, write data and write address into the register bank.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   hold         blocks acceptance of new requests while high
//   req          reg_file_wr_arbiter_if.slave: two valid/ready write requesters
//   wr_en        registered one-hot register enables (NUM_REGS bits)
//   wr_data      registered write data
//   wr_addr      registered write address
//   addr_err     one-cycle pulse: accepted address was >= NUM_REGS
//   conflict_cnt saturating count of cycles with both valid and hold low
//
// Build option: define REG_ZERO_PROTECT_EN to make register 0 unwritable
// (requests to address 0 are still accepted, but produce no enable).
module reg_file_wr_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_REGS    = 32,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  reg_file_wr_arbiter_if.slave   req,
  output logic [NUM_REGS-1:0]    wr_en,
  output logic [WORD_LENGTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic                   addr_err,
  output logic [15:0]            conflict_cnt
);

  // Decoder: addresses at or above NUM_REGS match no bit and yield all zero.
  function automatic logic [NUM_REGS-1:0] decode_onehot(input logic [ADDR_WIDTH-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      oh[i] = (a == ADDR_WIDTH'(i));
    end
    return oh;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                   prio_p0;
  logic                   gnt0;
  logic                   gnt1;
  logic                   xfer;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [WORD_LENGTH-1:0] sel_data;
  logic                   in_range;
  logic [NUM_REGS-1:0]    sel_en;
  logic                   sel_err;
  logic                   conflict;

  // Stage 0: combinational grant from current valids and priority pointer.
  always_comb begin
    gnt0     = !hold && req.req0_valid && (!req.req1_valid || !prio_p0);
    gnt1     = !hold && req.req1_valid && (!req.req0_valid ||  prio_p0);
    xfer     = gnt0 || gnt1;
    sel_addr = gnt1 ? req.req1_addr : req.req0_addr;
    sel_data = gnt1 ? req.req1_data : req.req0_data;
    in_range = ({1'b0, sel_addr} < (ADDR_WIDTH+1)'(NUM_REGS));
    sel_en   = decode_onehot(sel_addr);
    sel_err  = !in_range;
`ifdef REG_ZERO_PROTECT_EN
    if (sel_addr == '0) begin
      sel_en  = '0;
      sel_err = 1'b0;
    end
`endif
    conflict = req.req0_valid && req.req1_valid && !hold;
  end

  assign req.req0_ready = gnt0;
  assign req.req1_ready = gnt1;

  // Stage 1: registered write port toward the register bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_p0      <= 1'b0;
      wr_en        <= '0;
      wr_data      <= '0;
      wr_addr      <= '0;
      addr_err     <= 1'b0;
      conflict_cnt <= 16'd0;
    end else begin
      if (conflict) conflict_cnt <= sat_inc16(conflict_cnt);
      if (xfer) begin
        prio_p0  <= gnt0;          // winner 0 hands priority to 1, and vice versa
        wr_data  <= sel_data;
        wr_addr  <= sel_addr;
        wr_en    <= sel_en;
        addr_err <= sel_err;
      end else begin
        wr_en    <= '0;
        addr_err <= 1'b0;
      end
    end
  end

endmodule
